// File: rtl/pulse_train_pkg.sv
// Shared types and constants for the pulse train generator.
package pulse_train_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        FIN  = 2'd3
    } state_t;

    // A gap of at least one cycle lets the downstream synchronizer separate pulses.
    localparam int MIN_WIDTH = 1;
    localparam int MIN_GAP   = 1;

endpackage

// File: rtl/pulse_phase_cnt.sv
// Loadable down-counter timing one HIGH or LOW phase; tc marks the phase's last cycle.
module pulse_phase_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == W'(1));

endmodule

// File: rtl/pulse_train_gen.sv
// Emits W-high / G-low pulse trains of n pulses with a start/busy/done handshake.
module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] pulse_width,
    input  logic [CNT_W-1:0] gap_len,
    input  logic [NUM_W-1:0] num_pulses,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulse_idx
);

    state_t             state;
    logic [CNT_W-1:0]   width_q;
    logic [CNT_W-1:0]   gap_q;
    logic [NUM_W-1:0]   num_q;
    logic [CNT_W-1:0]   width_sat;
    logic [CNT_W-1:0]   gap_sat;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_load;
    logic               cnt_en;
    logic               cnt_tc;
    logic               last_pulse;

    assign width_sat  = (pulse_width < CNT_W'(MIN_WIDTH)) ? CNT_W'(MIN_WIDTH) : pulse_width;
    assign gap_sat    = (gap_len < CNT_W'(MIN_GAP)) ? CNT_W'(MIN_GAP) : gap_len;
    assign last_pulse = (pulse_idx == num_q - NUM_W'(1));
    assign busy       = (state != IDLE);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_val  = width_q;
        case (state)
            IDLE: begin
                cnt_load = start && !abort;
                cnt_val  = width_sat;
            end
            HIGH: begin
                cnt_en   = 1'b1;
                cnt_load = cnt_tc && !last_pulse;
                cnt_val  = gap_q;
            end
            LOW: begin
                cnt_en   = 1'b1;
                cnt_load = cnt_tc;
                cnt_val  = width_q;
            end
            default: ;
        endcase
    end

    pulse_phase_cnt #(.W(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (abort),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_val),
        .tc       (cnt_tc)
    );

    // pulse_out and done are registered alongside the state so they cannot glitch.
    // NOTE: async reset clears every register, including the latched config, for a known power-up state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            width_q   <= '0;
            gap_q     <= '0;
            num_q     <= '0;
            pulse_idx <= '0;
            pulse_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                pulse_out <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        width_q   <= width_sat;
                        gap_q     <= gap_sat;
                        num_q     <= num_pulses;
                        pulse_idx <= '0;
                        if (num_pulses == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state     <= HIGH;
                            pulse_out <= 1'b1;
                        end
                    end
                    HIGH: if (cnt_tc) begin
                        pulse_out <= 1'b0;
                        if (last_pulse) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= LOW;
                        end
                    end
                    LOW: if (cnt_tc) begin
                        state     <= HIGH;
                        pulse_out <= 1'b1;
                        pulse_idx <= pulse_idx + 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench: per-cycle comparison against a closed-form timing model of each train.
module tb_pulse_train_gen;

    localparam int CW = 8;
    localparam int NW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] pulse_width = '0;
    logic [CW-1:0] gap_len = '0;
    logic [NW-1:0] num_pulses = '0;
    logic          pulse_out;
    logic          busy;
    logic          done;
    logic [NW-1:0] pulse_idx;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pulse_train_gen #(.CNT_W(CW), .NUM_W(NW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .pulse_width (pulse_width),
        .gap_len     (gap_len),
        .num_pulses  (num_pulses),
        .pulse_out   (pulse_out),
        .busy        (busy),
        .done        (done),
        .pulse_idx   (pulse_idx)
    );

    // Starts a train in the current cycle (cycle 0) and checks every following cycle against
    // the timing formula. Returns positioned in the cycle after the last check.
    task automatic run_train(input string name, input int w_in, input int g_in, input int n,
                             input bit noise, input int abort_at);
        int w, g, p, t_done, t_end, t_ref, ek, ei;
        logic ep, eb, ed;
        logic [NW+2:0] exp_v, obs_v;
        w      = (w_in == 0) ? 1 : w_in;
        g      = (g_in == 0) ? 1 : g_in;
        p      = w + g;
        t_done = (n == 0) ? 1 : 1 + n * w + (n - 1) * g;
        t_end  = (abort_at > 0) ? abort_at + 1 : t_done + 2;
        start       = 1'b1;
        pulse_width = CW'(w_in);
        gap_len     = CW'(g_in);
        num_pulses  = NW'(n);
        for (int t = 1; t <= t_end; t++) begin
            @(posedge clk); #1;
            start       = noise && (t < t_done) && ($urandom_range(0, 2) == 0);
            abort       = (t == abort_at);
            pulse_width = CW'($urandom);
            gap_len     = CW'($urandom);
            num_pulses  = NW'($urandom);
            @(negedge clk);
            t_ref = (abort_at > 0 && t > abort_at) ? abort_at : t;
            ek    = (t_ref - 1) / p;
            ei    = (n == 0) ? 0 : ((ek < n - 1) ? ek : n - 1);
            if (abort_at > 0 && t > abort_at) begin
                ep = 1'b0; eb = 1'b0; ed = 1'b0;
            end else begin
                ep = (n > 0) && (ek < n) && (((t - 1) % p) < w);
                eb = (t <= t_done);
                ed = (t == t_done);
            end
            exp_v = {ep, eb, ed, NW'(ei)};
            obs_v = {pulse_out, busy, done, pulse_idx};
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_bad++;
                $display("FAIL %s cycle %0d: pulse/busy/done/idx got %b/%b/%b/%0d want %b/%b/%b/%0d",
                         name, t, pulse_out, busy, done, pulse_idx, ep, eb, ed, ei);
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({pulse_out, busy, done, pulse_idx} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got pulse/busy/done/idx %b/%b/%b/%0d want 0/0/0/0",
                     pulse_out, busy, done, pulse_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_train("w1_g3_n8", 1, 3, 8, 1'b0, 0);
        run_train("w3_g2_n2", 3, 2, 2, 1'b0, 0);
        run_train("n0", 2, 2, 0, 1'b0, 0);
    endtask

    task automatic test_saturation_busy_start();
        run_train("w0_g0_n3_noise", 0, 0, 3, 1'b1, 0);
    endtask

    task automatic test_abort();
        run_train("abort_w4_g4_n5", 4, 4, 5, 1'b0, 10);
        run_train("restart_after_abort", 2, 1, 2, 1'b0, 0);
    endtask

    task automatic test_start_abort_idle();
        start = 1'b1;
        abort = 1'b1;
        num_pulses = NW'(2);
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({pulse_out, busy, done} !== 3'b000) begin
            n_bad++;
            $display("FAIL start_abort_idle: got pulse/busy/done %b/%b/%b want 0/0/0",
                     pulse_out, busy, done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        pulse_width = CW'(5);
        gap_len = CW'(2);
        num_pulses = NW'(3);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        n_cmp++;
        if ({pulse_out, busy} !== 2'b11) begin
            n_bad++;
            $display("FAIL async_reset_pre: got pulse/busy %b/%b want 1/1", pulse_out, busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({pulse_out, busy, done, pulse_idx} !== '0) begin
            n_bad++;
            $display("FAIL async_reset_mid_high: got pulse/busy/done/idx %b/%b/%b/%0d want 0/0/0/0",
                     pulse_out, busy, done, pulse_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_train("after_async_reset", 2, 3, 3, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_train("random", int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                      int'($urandom_range(0, 6)), 1'b1, 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation_busy_start();
        test_abort();
        test_start_abort_idle();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
